// File: rtl/uart_mmio_fifo_pkg.sv
// Shared types for the FIFO-buffered MMIO UART.
package uart_mmio_fifo_pkg;

    localparam int ARCH_WIDTH = 32;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [31:0] {
        BR_9600   = 32'd9600,
        BR_19200  = 32'd19200,
        BR_38400  = 32'd38400,
        BR_57600  = 32'd57600,
        BR_115200 = 32'd115200
    } uart_baud_rate_t;

    typedef enum logic [1:0] {
        UART_CTRL = 2'd0,
        UART_RX   = 2'd1,
        UART_TX   = 2'd2
    } uart_addr_t;

    typedef struct packed {
        logic tx_ready;
        logic rx_valid;
    } uart_ctrl_t;

    typedef struct packed {
        logic       loopback;
        logic       frame_err;
        logic       rx_overrun;
        uart_ctrl_t ctrl;
    } uart_status_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_fsm_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push uses.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO UART with TX/RX FIFOs and sticky error flags.
// Define UART_LOOPBACK_EN to build the internal TX->RX loopback.
module uart_mmio_fifo
    import uart_mmio_fifo_pkg::*;
#(
    parameter int              CLK_FREQ_HZ = 100_000_000,
    parameter uart_baud_rate_t BAUD        = BR_115200,
    parameter int              FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_addr,
    input  logic [ARCH_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ARCH_WIDTH-1:0] rsp_data,
    input  logic                  uart_rx,
    output logic                  uart_tx
);

    localparam int BAUD_HZ = int'(BAUD);
    localparam int DIV = (CLK_FREQ_HZ + BAUD_HZ / 2) / BAUD_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (DIV < 4) begin : g_bad_div
        $error("baud divisor below 4");
    end

    uart_addr_t   addr;
    uart_status_t st;
    logic acc, wr, rd, ctrl_wr, tx_push, rx_pop;
    logic rx_ovr, frame_err, lb, rx_in;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic [ARCH_WIDTH-1:0] rd_data;
    logic unused_wdata;

    assign addr      = uart_addr_t'(req_addr);
    assign req_ready = !rsp_valid;
    assign acc       = req_valid && req_ready;
    assign wr        = acc && req_we;
    assign rd        = acc && !req_we;
    assign ctrl_wr   = wr && (addr == UART_CTRL);
    assign tx_push   = wr && (addr == UART_TX);
    assign rx_pop    = rd && (addr == UART_RX);
    assign unused_wdata = ^req_wdata[ARCH_WIDTH-1:8];

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (rst)          lb <= 1'b0;
        else if (ctrl_wr) lb <= req_wdata[4];
    end
    assign rx_in = lb ? uart_tx : uart_rx;
`else
    assign lb    = 1'b0;
    assign rx_in = uart_rx;
`endif

    // ---------------- TX path ----------------
    uart_fsm_t     tx_st, tx_st_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic          tx_q_n, tx_pop, tx_end;

    uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
        .din(req_wdata[7:0]), .head(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    assign tx_end = (tx_cnt == DIV_M1);

    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + CW'(1);
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_q_n   = uart_tx;
        tx_pop   = 1'b0;
        unique case (tx_st)
            IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_sh_n = tx_head;
                    tx_q_n  = 1'b0;
                    tx_st_n = START;
                end
            end
            START: if (tx_end) begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                tx_q_n   = tx_sh[0];
                tx_st_n  = DATA;
            end
            DATA: if (tx_end) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_q_n  = 1'b1;
                    tx_st_n = STOP;
                end else begin
                    tx_bit_n = tx_bit + 3'd1;
                    tx_sh_n  = tx_sh >> 1;
                    tx_q_n   = tx_sh[1];
                end
            end
            STOP: if (tx_end) begin
                tx_cnt_n = '0;
                // Chain straight into the next start bit when data waits.
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_sh_n = tx_head;
                    tx_q_n  = 1'b0;
                    tx_st_n = START;
                end else begin
                    tx_st_n = IDLE;
                end
            end
            default: tx_st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st   <= IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            uart_tx <= 1'b1;
        end else begin
            tx_st   <= tx_st_n;
            tx_cnt  <= tx_cnt_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            uart_tx <= tx_q_n;
        end
    end

    // ---------------- RX path ----------------
    uart_fsm_t     rx_st, rx_st_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic          rx_s1, rx_s2, rx_d;
    logic          rx_push, rx_ferr, rx_end, ovr_set;

    uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .head(rx_head),
        .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) {rx_s1, rx_s2, rx_d} <= 3'b111;
        else     {rx_s1, rx_s2, rx_d} <= {rx_in, rx_s1, rx_s2};
    end

    assign rx_end = (rx_cnt == DIV_M1);

    always_comb begin
        rx_st_n  = rx_st;
        rx_cnt_n = rx_cnt + CW'(1);
        rx_bit_n = rx_bit;
        rx_sh_n  = rx_sh;
        rx_push  = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_d && !rx_s2) rx_st_n = START;
            end
            START: if (rx_cnt == HALF_M1) begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_st_n  = rx_s2 ? IDLE : DATA;
            end
            DATA: if (rx_end) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s2, rx_sh[7:1]};
                rx_bit_n = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_st_n = STOP;
            end
            STOP: if (rx_end) begin
                rx_push = rx_s2;
                rx_ferr = !rx_s2;
                rx_st_n = IDLE;
            end
            default: rx_st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st  <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            rx_st  <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_bit <= rx_bit_n;
            rx_sh  <= rx_sh_n;
        end
    end

    // ---------------- flags and MMIO ----------------
    assign ovr_set = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_ovr    <= ovr_set ||
                         (rx_ovr && !(ctrl_wr && req_wdata[2]));
            frame_err <= rx_ferr ||
                         (frame_err && !(ctrl_wr && req_wdata[3]));
        end
    end

    always_comb begin
        st               = '0;
        st.ctrl.rx_valid = !rx_empty;
        st.ctrl.tx_ready = !tx_full;
        st.rx_overrun    = rx_ovr;
        st.frame_err     = frame_err;
        st.loopback      = lb;
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            addr == UART_CTRL: rd_data = ARCH_WIDTH'(st);
            addr == UART_RX:   rd_data = rx_empty ? '0 : ARCH_WIDTH'(rx_head);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (rd) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Randomized bench for uart_mmio_fifo against a queue-based model.
module tb_uart_mmio_fifo;
    import uart_mmio_fifo_pkg::*;

    localparam int CLK_HZ = 1_152_000;
    localparam int DIV    = (CLK_HZ + 115200 / 2) / 115200;
    localparam int DEPTH  = 8;
    localparam int FRAME  = UART_FRAME_BITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        uart_rx = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        uart_tx;

    always #5 clk = ~clk;

    uart_mmio_fifo #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD(BR_115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_lb = 1'b0;
    logic [7:0] tx_bytes [16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ctrl();
        return {27'd0, m_lb, m_ferr, m_ovr, 1'b1, rx_q.size() != 0};
    endfunction

    function automatic logic tx_exp_bit(input int k, input int n);
        int f;
        int b;
        f = k / FRAME;
        b = (k % FRAME) / DIV;
        if (f >= n) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return tx_bytes[f][b-1];
    endfunction

    // All tasks start and end at a falling clock edge.
    task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic mmio_read(input logic [1:0] a, output logic [31:0] d);
        int w;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("rd_latency", w, 0);
        d = rsp_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string tag);
        logic [31:0] d;
        mmio_read(2'd0, d);
        check(tag, d, exp_ctrl());
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        mmio_read(2'd1, d);
        e = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        check(tag, d, e);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (DIV) @(negedge clk);
        repeat (2) @(negedge clk);
        if (!stop)                 m_ferr = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                       m_ovr = 1'b1;
    endtask

    // Writes n bytes back-to-back while checking the line cycle by cycle.
    // One byte drains at once, so DEPTH+1 fit before writes drop.
    task automatic tx_burst(input int n);
        int exp_n;
        exp_n = (n > DEPTH + 1) ? DEPTH + 1 : n;
        fork
            begin
                logic [31:0] d;
                for (int i = 0; i < n; i++)
                    mmio_write(2'd2, {24'd0, tx_bytes[i]});
                if (n > DEPTH + 1) begin
                    mmio_read(2'd0, d);
                    check("ctrl_tx_full", d, exp_ctrl() & ~32'h2);
                end
            end
            begin
                @(negedge clk);
                check("tx_pre_start", uart_tx, 1'b1);
                for (int k = 0; k < exp_n * FRAME + 10; k++) begin
                    @(negedge clk);
                    check("tx_line", uart_tx, tx_exp_bit(k, exp_n));
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          lows;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_req_ready", req_ready, 1'b1);
        check_ctrl("ctrl_reset");
        read_rx("rx_empty_read");
        mmio_read(2'd3, d);
        check("rd_addr3", d, 32'd0);
        mmio_read(2'd2, d);
        check("rd_tx_addr", d, 32'd0);

        tx_bytes[0] = 8'hA5;
        tx_bytes[1] = 8'h3C;
        tx_burst(2);
        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
        tx_burst(3);
        for (int i = 0; i < 10; i++) tx_bytes[i] = 8'($urandom);
        tx_burst(10);

        rx_frame(8'h5A, 1'b1);
        check_ctrl("ctrl_rx_valid");
        read_rx("rx_5a");
        check_ctrl("ctrl_rx_drained");

        repeat (6) begin
            rx_frame(8'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) read_rx("rx_rand");
        end
        while (rx_q.size() != 0) read_rx("rx_drain");
        check_ctrl("ctrl_rand_done");

        repeat (DEPTH + 1) rx_frame(8'($urandom), 1'b1);
        check_ctrl("ctrl_overrun");
        repeat (DEPTH) read_rx("rx_ovr_order");
        check_ctrl("ctrl_ovr_empty");
        read_rx("rx_ovr_lost");
        mmio_write(2'd0, 32'h4);
        m_ovr = 1'b0;
        check_ctrl("ctrl_ovr_clear");

        rx_frame(8'($urandom), 1'b0);
        check_ctrl("ctrl_frame_err");
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_ctrl("ctrl_glitch");
        mmio_write(2'd0, 32'h8);
        m_ferr = 1'b0;
        check_ctrl("ctrl_ferr_clear");

        mmio_write(2'd1, 32'h77);
        check_ctrl("ctrl_wr_rx_ignored");

        b = 8'($urandom);
        rx_frame(b, 1'b1);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 2'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 2'd2;
        req_wdata = 32'h55;
        void'(rx_q.pop_front());
        repeat (5) begin
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", rsp_data, {24'd0, b});
            check("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release", rsp_valid, 1'b0);
        check("stall_ready_back", req_ready, 1'b1);
        lows = 0;
        repeat (5) begin
            @(negedge clk);
            if (!uart_tx) lows++;
        end
        check("stall_wr_blocked", lows, 0);

`ifdef UART_LOOPBACK_EN
        mmio_write(2'd0, 32'h10);
        m_lb = 1'b1;
        check_ctrl("ctrl_lb_on");
        uart_rx = 1'b0;
        mmio_write(2'd2, 32'hC3);
        repeat (FRAME + 10) @(negedge clk);
        rx_q.push_back(8'hC3);
        check_ctrl("ctrl_lb_rx");
        read_rx("rx_lb");
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        mmio_write(2'd0, 32'h0);
        m_lb = 1'b0;
        check_ctrl("ctrl_lb_off");
`else
        mmio_write(2'd0, 32'h10);
        check_ctrl("ctrl_lb_absent");
`endif

        rx_frame(8'($urandom), 1'b0);
        rx_frame(8'($urandom), 1'b1);
        check_ctrl("ctrl_pre_reset");
        mmio_write(2'd2, 32'h00);
        repeat (30) @(negedge clk);
        check("tx_mid_frame", uart_tx, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_lb   = 1'b0;
        check("rst_mid_tx", uart_tx, 1'b1);
        lows = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (!uart_tx) lows++;
        end
        check("rst_frame_abandoned", lows, 0);
        check_ctrl("ctrl_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_fifo.md
# uart_mmio_fifo

Parametrised UART peripheral for the core's MMIO space. It is the next generation of the single-register UART: configurable clock and baud, TX and RX FIFOs of configurable depth, sticky overrun and framing-error flags, and an optional internal loopback. It sits behind the data-side MMIO decoder. Requests arrive on an `rv_if_da` request channel and read data returns on an `rv_if` response channel.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: core clock frequency.
- `BAUD` (`uart_baud_rate_t`), default `BR_115200`: line rate.
- `FIFO_DEPTH`, default 8: entries per FIFO. Must be a power of 2 and ≥2; checked at elaboration with `is_pow2`.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset. Synchronous, active-high; `clk` is the only clock.
- `req`  `rv_if_da.RX`  AW=2 (`uart_addr_t`), DW=`ARCH_WIDTH`  MMIO read/write requests. A request is a write when a write strobe is set (`req_we  in  1`, sideband).
- `rsp`  `rv_if.TX`  DW=`ARCH_WIDTH`  read data.
- `uart_rx`  in  1  serial input, asynchronous.
- `uart_tx`  out  1  serial output.

## Operation
- Baud divisor: `DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD` (rounded). Elaboration fails if `DIV < 4`.

Register map:
- `UART_CTRL` (read): bit0 `rx_valid` (RX FIFO non-empty), bit1 `tx_ready` (TX FIFO not full), bit2 `rx_overrun`, bit3 `frame_err`, bit4 `loopback`. All other bits read 0.
- `UART_CTRL` (write): writing 1 to bit2 or bit3 clears that flag. Bit4 sets loopback.
- `UART_RX` (read): returns the FIFO head zero-extended in [7:0] and pops it. Reading while empty returns 0 and pops nothing.
- `UART_TX` (write): pushes wdata[7:0]. A write while the TX FIFO is full is dropped.
- Writes to `UART_RX`, reads of `UART_TX`, and address 3 have no effect. Such reads return 0.

Handshake:
- `req.ready = !rsp.valid`.
- A write completes on the accepting edge and produces no response.
- A read produces `rsp.valid` on the next cycle, held with stable data until `rsp.ready`.

TX FSM (IDLE → START → DATA → STOP → IDLE):
- In IDLE with the FIFO non-empty, it pops the head and drives the start bit.
- START, each of the 8 DATA bits (LSB first), and STOP each last `DIV` cycles.
- At the end of STOP it returns to IDLE, or goes directly to START if the FIFO is non-empty, with no idle gap.

RX FSM (IDLE → START → DATA → STOP → IDLE):
- Input: 2-FF synchronizer, both stages reset to 1.
- IDLE: a falling edge moves to START.
- START: samples at `DIV/2`. If the line is high, it is a glitch and the FSM returns to IDLE.
- DATA: then samples every `DIV` cycles.
- STOP: at the mid-stop sample, high means the byte is pushed; low means the byte is discarded and `frame_err` is set.
- If the FIFO is full at push time, the byte is discarded and `rx_overrun` is set.

Boundary cases:
- Simultaneous push and pop on a full FIFO: both succeed and occupancy is unchanged.
- Simultaneous pop and push on an empty FIFO: the pop is ignored and the push succeeds.
- Flag set and software clear in the same cycle: set wins.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits; full/empty is decided by comparing the MSBs.

## Timing
- Reset values: `uart_tx`=1, `rsp.valid`=0, `rsp.data`=0, `req.ready`=1. FIFOs empty, flags 0, loopback 0, both FSMs IDLE.
- Reset mid-frame abandons the frame. `uart_tx` is 1 after the reset edge.
- Read latency is 1 cycle. CTRL status reflects state before the accepting edge.
- TX: the first start bit appears 2 cycles after the TX write is accepted (push, then pop/drive). A frame lasts `10*DIV` cycles.
- RX: the byte is visible in `rx_valid` 1 cycle after the mid-stop sample, which is about `9.5*DIV` + 3 cycles after the start edge.

## Configuration
`UART_LOOPBACK_EN`:
- Defined: CTRL bit4 is writable. When it is 1, the RX synchronizer input is `uart_tx` and the external `uart_rx` is ignored, while `uart_tx` still drives the pin.
- Undefined: bit4 reads 0, writes are ignored, and no mux is built.

## Structure
- Shared types package gets:
  - `uart_status_t`: packed `{loopback, frame_err, rx_overrun, uart_ctrl_t}`.
  - `UART_FRAME_BITS = 10`.
  - `uart_fsm_t` enum: IDLE/START/DATA/STOP.
- Sub-module `uart_fifo`: synchronous FIFO, params `W` and `DEPTH`, with push/pop/full/empty/head. It is instantiated twice.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1_152_000 and `BR_115200`, so `DIV`=10.
- Reset, then read CTRL → `rsp.data`=0x2, `uart_tx`=1 throughout.
- Write TX 0xA5, 0x3C back-to-back → `uart_tx` gives start at cycle+2, then bits 1,0,1,0,0,1,0,1, stop, then immediately the 0x3C frame. 200 cycles total.
- Drive RX frame 0x5A at 10 cycles/bit → CTRL=0x3, then RX read returns 0x5A, then CTRL=0x2.
- Receive 9 bytes with `FIFO_DEPTH`=8 and no reads → CTRL bit2 set, first 8 bytes read back in order, 9th lost. Write CTRL 0x4 → bit2 clears.
- RX frame with stop bit 0 → no push, CTRL=0xA. A 3-cycle low glitch on `uart_rx` → no state change.
- With `UART_LOOPBACK_EN`: write CTRL 0x10, write TX 0xC3 → RX read returns 0xC3 and external `uart_rx` held at 0 is ignored. Also: hold `rsp.ready`=0 for 5 cycles → data stable and `req.ready`=0 throughout.
